sram_controller: RTL and testbench

Multi-cycle controller between the MEM stage and a 16-bit-wide external asynchronous SRAM (256K x 16). Converts a 32-bit word read/write from the pipeline into two 16-bit SRAM accesses plus a programmable settle period. While an access is in flight it holds `ready` low; the top level uses `ready` to freeze every pipeline register and the PC.

---
 rtl/sram_controller_if.sv | 28 ++
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle for the SRAM controller.
// The MEM stage is the master; the controller is the slave.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit pipeline load/store into two 16-bit accesses to an external
// asynchronous SRAM, then waits a programmable settle period before releasing the pipeline.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for rd_en/wr_en; request latched on acceptance
// LOW   | half-word 0 (bits [15:0]) on the bus
// HIGH  | half-word 1 (bits [31:16]) on the bus
// WAIT  | settle period, WE_N high, DQ released
// DONE  | ready high for one cycle, read_data holds the full word
module sram_controller #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : (WAIT_CYCLES - 1));

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic        req_wr;
    logic [16:0] req_word;
    logic [31:0] req_wdata;
    logic [31:0] read_data_q;
    logic        accept;
    logic [16:0] word_idx;
    logic        dq_oe;
    logic [15:0] dq_out;

    // Only bits [18:2] of the rebased byte address select a word; the rest wrap away.
    assign word_idx = 17'((bus.address - ADDR_BASE) >> 2);
    assign accept   = (state == S_IDLE) && (bus.rd_en || bus.wr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            req_wr      <= 1'b0;
            req_word    <= 17'd0;
            req_wdata   <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                req_wr    <= bus.wr_en && !bus.rd_en;
                req_word  <= word_idx;
                req_wdata <= bus.write_data;
            end
            if (state == S_LOW && !req_wr) begin
                read_data_q[15:0] <= SRAM_DQ;
            end
            if (state == S_HIGH && !req_wr) begin
                read_data_q[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        SRAM_ADDR     = 18'd0;
        SRAM_WE_N     = 1'b1;
        dq_oe         = 1'b0;
        dq_out        = 16'd0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                SRAM_ADDR  = {req_word, 1'b0};
                SRAM_WE_N  = !req_wr;
                dq_oe      = req_wr;
                dq_out     = req_wdata[15:0];
                state_next = S_HIGH;
            end
            S_HIGH: begin
                SRAM_ADDR  = {req_word, 1'b1};
                SRAM_WE_N  = !req_wr;
                dq_oe      = req_wr;
                dq_out     = req_wdata[31:16];
                state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_next = 4'd0;
                    state_next    = S_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

    assign bus.read_data = read_data_q;
    assign bus.ready     = ((state == S_IDLE) && !(bus.rd_en || bus.wr_en)) || (state == S_DONE);

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a small SRAM model on DQ plus a second
// instance with no settle cycles.
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    sram_controller_if bus();
    sram_controller_if bus0();

    wire  [15:0] sram_dq;
    wire  [15:0] sram_dq0;
    logic [17:0] sram_addr;
    logic [17:0] sram_addr0;
    logic        we_n, we_n0;
    logic        ub_n, lb_n, ce_n, oe_n;
    logic        ub_n0, lb_n0, ce_n0, oe_n0;

    // When probe is set the model drives a marker instead of memory contents,
    // so a released bus reads back as 16'hC3C3.
    logic [15:0] mem [256];
    logic        probe;

    assign sram_dq  = we_n  ? (probe ? 16'hC3C3 : mem[sram_addr[7:0]]) : 16'bz;
    assign sram_dq0 = we_n0 ? 16'hC3C3 : 16'bz;

    always @(posedge clk) begin
        if (!we_n) mem[sram_addr[7:0]] <= sram_dq;
    end

    sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .SRAM_DQ(sram_dq0), .SRAM_ADDR(sram_addr0), .SRAM_WE_N(we_n0),
        .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] obs_rd    [8];
    logic        obs_ready [8];
    logic [17:0] obs_addr  [8];
    logic [15:0] obs_dq    [8];
    logic        obs_we    [8];

    // Issues one request in cycle 0 and records cycles 0..7; inputs are scrambled
    // afterwards. rst_cycle >= 0 pulses reset during that cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic change_addr,
                              input int rst_cycle);
        @(posedge clk); #1;
        bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = wdata;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (cyc == 1) begin
                    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.write_data = 32'hFFFF_FFFF;
                end
                if (cyc == 2 && change_addr) bus.address = 32'h0000_0F00;
                if (cyc == rst_cycle) rst = 1'b1;
                if (cyc == rst_cycle + 1) rst = 1'b0;
            end
            @(negedge clk);
            obs_rd[cyc]    = bus.read_data;
            obs_ready[cyc] = bus.ready;
            obs_addr[cyc]  = sram_addr;
            obs_dq[cyc]    = sram_dq;
            obs_we[cyc]    = we_n;
        end
    endtask

    logic        r0_ready [6];
    logic [31:0] r0_data  [6];
    logic [17:0] r0_addr  [6];

    task automatic run_access0(input logic rd, input logic wr, input logic [31:0] addr);
        @(posedge clk); #1;
        bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = addr; bus0.write_data = 32'h0102_0304;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
            end
            @(negedge clk);
            r0_ready[cyc] = bus0.ready;
            r0_data[cyc]  = bus0.read_data;
            r0_addr[cyc]  = sram_addr0;
        end
    endtask

    logic any_we_low;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h5A5A;
        probe = 1'b1;
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = 32'd0; bus.write_data = 32'd0;
        bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = 32'd0; bus0.write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_rdata", bus.read_data, 32'd0);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_dq_released", 32'(sram_dq), 32'h0000_C3C3);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("tie_offs", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);

        // Single write
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, -1);
        chk("wr_c1_addr", 32'(obs_addr[1]), 32'd0);
        chk("wr_c1_dq", 32'(obs_dq[1]), 32'h0000_BEEF);
        chk("wr_c1_we_n", 32'(obs_we[1]), 32'd0);
        chk("wr_c2_addr", 32'(obs_addr[2]), 32'd1);
        chk("wr_c2_dq", 32'(obs_dq[2]), 32'h0000_DEAD);
        chk("wr_c2_we_n", 32'(obs_we[2]), 32'd0);
        chk("wr_c3_we_n", 32'(obs_we[3]), 32'd1);
        chk("wr_c3_dq_released", 32'(obs_dq[3]), 32'h0000_C3C3);
        chk("wr_ready_c0_4", {27'd0, obs_ready[0], obs_ready[1], obs_ready[2],
                              obs_ready[3], obs_ready[4]}, 32'd0);
        chk("wr_ready_c5", 32'(obs_ready[5]), 32'd1);
        chk("wr_ready_c6_idle", 32'(obs_ready[6]), 32'd1);
        chk("wr_rdata_unchanged", obs_rd[5], 32'd0);

        // Readback
        probe = 1'b0;
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, -1);
        chk("rd1024_data", obs_rd[5], 32'hDEAD_BEEF);
        chk("rd_ready_c4", 32'(obs_ready[4]), 32'd0);
        chk("rd_ready_c5", 32'(obs_ready[5]), 32'd1);
        any_we_low = 1'b0;
        for (int c = 0; c < 8; c++) if (!obs_we[c]) any_we_low = 1'b1;
        chk("rd_we_n_high", 32'(any_we_low), 32'd0);

        // Address mapping
        probe = 1'b1;
        run_access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 1'b0, -1);
        chk("map_c1_addr", 32'(obs_addr[1]), 32'd4);
        chk("map_c2_addr", 32'(obs_addr[2]), 32'd5);
        chk("map_wr_keeps_rdata", obs_rd[5], 32'hDEAD_BEEF);
        probe = 1'b0;
        run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, -1);
        chk("rd1032_data", obs_rd[5], 32'h1234_5678);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, -1);
        chk("rd1024_again", obs_rd[5], 32'hDEAD_BEEF);

        // Simultaneous rd/wr plus address change mid-access
        run_access(1'b1, 1'b1, 32'd1032, 32'hAAAA_5555, 1'b1, -1);
        chk("both_c1_addr", 32'(obs_addr[1]), 32'd4);
        chk("both_c2_addr_stable", 32'(obs_addr[2]), 32'd5);
        chk("both_is_read", obs_rd[5], 32'h1234_5678);
        any_we_low = 1'b0;
        for (int c = 0; c < 8; c++) if (!obs_we[c]) any_we_low = 1'b1;
        chk("both_we_n_high", 32'(any_we_low), 32'd0);
        run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, -1);
        chk("both_mem_unchanged", obs_rd[5], 32'h1234_5678);

        // Reset in the HIGH cycle of a write
        probe = 1'b1;
        run_access(1'b0, 1'b1, 32'd1040, 32'h0BAD_F00D, 1'b0, 2);
        chk("rstmid_c2_we_n", 32'(obs_we[2]), 32'd0);
        chk("rstmid_ready", 32'(obs_ready[3]), 32'd1);
        chk("rstmid_dq_released", 32'(obs_dq[3]), 32'h0000_C3C3);
        chk("rstmid_we_n", 32'(obs_we[3]), 32'd1);
        chk("rstmid_rdata_cleared", obs_rd[3], 32'd0);
        chk("rstmid_c4_ready", 32'(obs_ready[4]), 32'd1);

        // No settle cycles
        run_access0(1'b0, 1'b1, 32'd1028);
        chk("w0_c1_addr", 32'(r0_addr[1]), 32'd2);
        chk("w0_ready_c2", 32'(r0_ready[2]), 32'd0);
        chk("w0_ready_c3", 32'(r0_ready[3]), 32'd1);
        run_access0(1'b1, 1'b0, 32'd1024);
        chk("w0_rd_ready_c3", 32'(r0_ready[3]), 32'd1);
        chk("w0_rd_data", r0_data[3], 32'hC3C3_C3C3);
        chk("w0_ties", {28'd0, ub_n0, lb_n0, ce_n0, oe_n0}, 32'd0);
        chk("w0_we_idle", 32'(we_n0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
